// File: rtl/ysyx_25020047_mem_pkg.sv
// rtl/ysyx_25020047_mem_pkg.sv - shared types and constants for the data-memory responder
package ysyx_25020047_mem_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    localparam logic [31:0] DMEM_BASE_ADDR = 32'h8000_0000;

    // Fibonacci taps 16,14,13,11 expressed as a bit mask over lfsr[15:0]
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Unsigned wrap makes addresses below base land far out of range
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] depth_words);
        logic [31:0] off;
        off = addr - base;
        return (off >> 2) < depth_words;
    endfunction

endpackage

// File: rtl/ysyx_25020047_dmem_resp_if.sv
// rtl/ysyx_25020047_dmem_resp_if.sv - request/response channel bundle for the data-memory responder
interface ysyx_25020047_dmem_resp_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/ysyx_25020047_lfsr16.sv
// rtl/ysyx_25020047_lfsr16.sv - 16-bit Fibonacci LFSR used to jitter response timing
module ysyx_25020047_lfsr16
    import ysyx_25020047_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] out
);

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= LFSR_SEED;
        end else if (en) begin
            out <= {out[14:0], ^(out & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/ysyx_25020047_dmem_resp.sv
// rtl/ysyx_25020047_dmem_resp.sv - fixed-latency data-memory responder; YSYX_25020047_DMEM_RAND_DELAY_EN adds random delay
module ysyx_25020047_dmem_resp
    import ysyx_25020047_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    ysyx_25020047_dmem_resp_if.slave    bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];

    dmem_state_e   state;
    logic [15:0]   cnt;
    logic          wen_q;
    logic          range_q;
    logic [AW-1:0] idx_q;

    logic          req_ready_q;
    logic          resp_valid_q;
    logic [31:0]   resp_rdata_q;
    logic          resp_err_q;

    logic [31:0]   req_off;
    logic          req_in_range;
    logic [AW-1:0] req_idx;
    logic          accept;
    logic [15:0]   extra;
    logic [15:0]   lat_load;
    logic          gate_first;

    logic          sel_wen;
    logic          sel_range;
    logic [AW-1:0] sel_idx;
    logic [31:0]   rdata_next;

    assign req_off      = bus.req_addr - BASE_ADDR;
    assign req_in_range = addr_in_range(bus.req_addr, BASE_ADDR, 32'(DEPTH_WORDS));
    assign req_idx      = req_off[AW+1:2];
    assign accept       = bus.req_valid && req_ready_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_off[31:AW+2], req_off[1:0]};

`ifdef YSYX_25020047_DMEM_RAND_DELAY_EN
    logic [15:0] lfsr;

    ysyx_25020047_lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .out (lfsr)
    );

    assign extra      = {13'd0, lfsr[2:0]};
    assign gate_first = lfsr[3];

    logic unused_lfsr_bits;
    assign unused_lfsr_bits = ^lfsr[15:4];
`else
    assign extra      = 16'd0;
    assign gate_first = 1'b0;
`endif

    assign lat_load = 16'(LATENCY - 1) + extra;

    // When RESP is entered straight from IDLE the request has not been captured yet
    always_comb begin
        sel_wen   = wen_q;
        sel_range = range_q;
        sel_idx   = idx_q;
        if (state == DMEM_IDLE) begin
            sel_wen   = bus.req_wen;
            sel_range = req_in_range;
            sel_idx   = req_idx;
        end
        rdata_next = (sel_range && !sel_wen) ? mem[sel_idx] : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst && accept && req_in_range && bus.req_wen) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.req_wmask[i]) begin
                    mem[req_idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= DMEM_IDLE;
            cnt          <= 16'd0;
            wen_q        <= 1'b0;
            range_q      <= 1'b0;
            idx_q        <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state)
                DMEM_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        wen_q       <= bus.req_wen;
                        range_q     <= req_in_range;
                        idx_q       <= req_idx;
                        cnt         <= lat_load;
                        if (lat_load == 16'd0) begin
                            state        <= DMEM_RESP;
                            resp_valid_q <= !gate_first;
                            resp_rdata_q <= rdata_next;
                            resp_err_q   <= !req_in_range;
                        end else begin
                            state <= DMEM_WAIT;
                        end
                    end
                end
                DMEM_WAIT: begin
                    cnt <= cnt - 16'd1;
                    if (cnt == 16'd1) begin
                        state        <= DMEM_RESP;
                        resp_valid_q <= !gate_first;
                        resp_rdata_q <= rdata_next;
                        resp_err_q   <= !range_q;
                    end
                end
                DMEM_RESP: begin
                    // A gated first cycle is released unconditionally, bounding the jitter
                    if (!resp_valid_q) begin
                        resp_valid_q <= 1'b1;
                    end else if (bus.resp_ready) begin
                        state        <= DMEM_IDLE;
                        req_ready_q  <= 1'b1;
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= 32'd0;
                        resp_err_q   <= 1'b0;
                    end
                end
                default: state <= DMEM_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_ysyx_25020047_dmem_resp.sv
// tb/tb_ysyx_25020047_dmem_resp.sv - self-checking bench for the data-memory responder
module tb_ysyx_25020047_dmem_resp;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 4096;
    localparam int          LAT   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_25020047_dmem_resp_if bus();

    ysyx_25020047_dmem_resp #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc_cyc;
        bit          seen;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mm [int unsigned];
    int          cyc = 0;
    logic [31:0] last_rdata;
    logic        last_err;
    int          last_lat;

    exp_t        e_tmp;
    int unsigned k_tmp;
    logic [31:0] w_tmp;
    int          lat_tmp;

    function automatic bit m_in_range(input logic [31:0] a);
        longint unsigned aa;
        aa = a;
        return (aa >= 64'h8000_0000) && (aa < 64'h8000_0000 + 4 * DEPTH);
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() != 0)
                chk("req_ready_busy", {31'd0, bus.req_ready}, 32'd0);
            if (bus.resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("stale_resp", {31'd0, bus.resp_valid}, 32'd0);
                end else begin
                    if (!exp_q[0].seen) begin
                        lat_tmp = cyc - exp_q[0].acc_cyc;
                        last_lat = lat_tmp;
                        exp_q[0].seen = 1'b1;
`ifdef YSYX_25020047_DMEM_RAND_DELAY_EN
                        chk("latency_range", {31'd0, (lat_tmp >= LAT) && (lat_tmp <= LAT + 8)}, 32'd1);
`else
                        chk("latency", lat_tmp, LAT);
`endif
                    end
                    chk("resp_rdata", bus.resp_rdata, exp_q[0].rdata);
                    chk("resp_err", {31'd0, bus.resp_err}, {31'd0, exp_q[0].err});
                    if (bus.resp_ready) begin
                        last_rdata = bus.resp_rdata;
                        last_err   = bus.resp_err;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (bus.req_valid && bus.req_ready) begin
                k_tmp = (bus.req_addr - BASE) >> 2;
                e_tmp.err     = !m_in_range(bus.req_addr);
                e_tmp.acc_cyc = cyc;
                e_tmp.seen    = 1'b0;
                e_tmp.rdata   = 32'd0;
                if (!e_tmp.err) begin
                    w_tmp = mm.exists(k_tmp) ? mm[k_tmp] : 32'd0;
                    if (bus.req_wen) begin
                        for (int i = 0; i < 4; i++)
                            if (bus.req_wmask[i]) w_tmp[8*i +: 8] = bus.req_wdata[8*i +: 8];
                        mm[k_tmp] = w_tmp;
                    end else begin
                        e_tmp.rdata = w_tmp;
                    end
                end
                exp_q.push_back(e_tmp);
            end
        end
    end

    task automatic send_req(input logic wen, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wmask);
        int n;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_wen   = wen;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wmask = wmask;
        forever begin
            @(negedge clk);
            if (bus.req_ready) break;
            n++;
            if (n > 50) begin
                chk("accept_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_wen   = 1'b1;
        bus.req_addr  = 32'hFFFF_FFFF;
        bus.req_wdata = 32'h5A5A_5A5A;
        bus.req_wmask = 4'hF;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) break;
            n++;
            if (n > 100) begin
                chk("resp_timeout", 32'd1, 32'd0);
                break;
            end
        end
    endtask

    task automatic xact(input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask);
        send_req(wen, addr, wdata, wmask);
        wait_done();
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_wen    = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.req_wmask  = 4'd0;
        bus.resp_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);

        xact(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
        chk("wr_err", {31'd0, last_err}, 32'd0);
        chk("wr_rdata", last_rdata, 32'd0);
        xact(1'b0, 32'h8000_0010, 32'h0, 4'h0);
        chk("rd_word", last_rdata, 32'hDEAD_BEEF);
        chk("rd_lat", last_lat, LAT);
        xact(1'b0, 32'h8000_0013, 32'h0, 4'h0);
        chk("rd_unaligned", last_rdata, 32'hDEAD_BEEF);
        xact(1'b1, 32'h8000_0010, 32'h0000_0000, 4'h0);
        xact(1'b0, 32'h8000_0010, 32'h0, 4'h0);
        chk("rd_mask0", last_rdata, 32'hDEAD_BEEF);

        xact(1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF);
        xact(1'b1, 32'h8000_0020, 32'h00AB_0000, 4'b0100);
        xact(1'b0, 32'h8000_0020, 32'h0, 4'h0);
        chk("rd_lane", last_rdata, 32'h11AB_3344);

        xact(1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF);
        xact(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0);
        chk("oor_low_err", {31'd0, last_err}, 32'd1);
        chk("oor_low_rdata", last_rdata, 32'd0);
        xact(1'b1, 32'h8000_4000, 32'h1234_5678, 4'hF);
        chk("oor_high_err", {31'd0, last_err}, 32'd1);
        xact(1'b0, 32'h8000_0000, 32'h0, 4'h0);
        chk("word0_kept", last_rdata, 32'hCAFE_F00D);
        xact(1'b1, 32'h8000_3FFC, 32'h0BAD_CAFE, 4'hF);
        xact(1'b0, 32'h8000_3FFC, 32'h0, 4'h0);
        chk("last_word", last_rdata, 32'h0BAD_CAFE);
        chk("last_word_err", {31'd0, last_err}, 32'd0);

        bus.resp_ready = 1'b0;
        send_req(1'b0, 32'h8000_0020, 32'h0, 4'h0);
        for (int n = 0; n < 40 && !bus.resp_valid; n++) @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            chk("bp_valid", {31'd0, bus.resp_valid}, 32'd1);
            chk("bp_rdata", bus.resp_rdata, 32'h11AB_3344);
            chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("bp_release_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("bp_release_rdata", bus.resp_rdata, 32'd0);

        send_req(1'b0, 32'h8000_0010, 32'h0, 4'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("midrst_ready", {31'd0, bus.req_ready}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1 chk("midrst_after_ready", {31'd0, bus.req_ready}, 32'd1);
        repeat (6) @(posedge clk);
        #1 chk("midrst_no_stale", {31'd0, bus.resp_valid}, 32'd0);
        xact(1'b0, 32'h8000_0010, 32'h0, 4'h0);
        chk("midrst_mem_kept", last_rdata, 32'hDEAD_BEEF);

`ifdef YSYX_25020047_DMEM_RAND_DELAY_EN
        for (int i = 0; i < 16; i++)
            xact(1'b1, BASE + 32'(4 * i), 32'h1000_0001 * 32'(i + 1), 4'hF);
        for (int i = 0; i < 100; i++)
            xact(1'b0, BASE + 32'(4 * $urandom_range(0, 15)), 32'h0, 4'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
